// File: rtl/req_pending_dispatcher_pkg.sv
// Shared constants, state encoding and helpers for the request dispatcher.
package req_pending_dispatcher_pkg;

  localparam int unsigned DISP_WIDTH = 8;
  localparam int unsigned DISP_IDX_W = 3;

  // Dispatcher state; PRESENT is exactly the out_valid_o level.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [DISP_WIDTH-1:0] onehot(input logic [DISP_IDX_W-1:0] idx);
    logic [DISP_WIDTH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/req_pending_dispatcher_enc.sv
// Combinational priority encoder: the highest set bit wins, index 0 when empty.
module priority_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] in_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] num_o
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    valid_o = 1'b0;
    num_o   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        valid_o = 1'b1;
        num_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_pending_dispatcher.sv
// Accumulates request pulses into a pending register and dispatches the
// highest-priority enabled index over a valid/ready handshake.
module req_pending_dispatcher
  import req_pending_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH = DISP_WIDTH,
  parameter int unsigned IDX_W = DISP_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_num_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             overflow_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] out_num_q, out_num_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;

  logic             fire;
  logic [WIDTH-1:0] clear_vec;
  logic [WIDTH-1:0] eligible;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_num;

  priority_encoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .in_i    (eligible),
    .valid_o (enc_valid),
    .num_o   (enc_num)
  );

  // State, grant, pending and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_num_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_num_q  <= out_num_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Next pending (clear served bit before merging new requests) and next grant.
  always_comb begin
    fire       = (state_q == PRESENT) && out_ready_i;
    clear_vec  = fire ? onehot(out_num_q) : '0;
    pending_d  = (pending_q & ~clear_vec) | req_i;
    overflow_d = |(req_i & pending_q & ~clear_vec);
    eligible   = pending_d & mask_i;
    state_d    = state_q;
    out_num_d  = out_num_q;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d   = PRESENT;
          out_num_d = enc_num;
        end
      end
      PRESENT: begin
        if (fire) begin
          if (enc_valid) begin
            out_num_d = enc_num;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid_o = (state_q == PRESENT);
    out_num_o   = out_num_q;
    pending_o   = pending_q;
    overflow_o  = overflow_q;
  end

endmodule

// File: tb/tb_req_pending_dispatcher.sv
// Self-checking bench for req_pending_dispatcher: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_req_pending_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_i = '0;
  logic [7:0] mask_i = '0;
  logic       out_valid_o;
  logic [2:0] out_num_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] pending_o;
  logic       overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_pend  = 0;
  int m_valid = 0;
  int m_num   = 0;
  int m_ovf   = 0;

  req_pending_dispatcher #(.WIDTH(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .mask_i      (mask_i),
    .out_valid_o (out_valid_o),
    .out_num_o   (out_num_o),
    .out_ready_i (out_ready_i),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic int highest(input int v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // Advance one clock; the model follows the behavioural rules of the block.
  task automatic step();
    int fire, clr, nxt, elig;
    int n_valid, n_num, n_ovf;
    fire = (m_valid != 0) && out_ready_i;
    clr  = fire ? (1 << m_num) : 0;
    nxt  = (m_pend & ~clr & 8'hFF) | int'(req_i);
    n_ovf = ((int'(req_i) & m_pend & ~clr) != 0) ? 1 : 0;
    elig = nxt & int'(mask_i);
    n_valid = m_valid;
    n_num   = m_num;
    if (m_valid == 0 || fire) begin
      if (elig != 0) begin
        n_valid = 1;
        n_num   = highest(elig);
      end else begin
        n_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    m_pend  = nxt;
    m_valid = n_valid;
    m_num   = n_num;
    m_ovf   = n_ovf;
  endtask

  task automatic model_reset();
    m_pend = 0; m_valid = 0; m_num = 0; m_ovf = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_tests++;
    if ({out_valid_o, out_num_o, pending_o, overflow_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b n=%0d p=%h o=%b exp all zero",
               out_valid_o, out_num_o, pending_o, overflow_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got valid=%b exp 0", out_valid_o);
    end
  endtask

  task automatic test_burst();
    int exp_num[4] = '{7, 5, 2, 1};
    mask_i = 8'hFF; out_ready_i = 1'b1; req_i = 8'b10100110;
    for (int k = 0; k < 4; k++) begin
      step();
      req_i = '0;
      n_tests++;
      if (out_valid_o !== 1'b1 || int'(out_num_o) != exp_num[k]) begin
        n_fail++;
        $display("FAIL burst_num[%0d] got v=%b n=%0d exp v=1 n=%0d", k, out_valid_o, out_num_o, exp_num[k]);
      end
    end
    step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      n_fail++;
      $display("FAIL burst_drain got v=%b p=%h exp v=0 p=00", out_valid_o, pending_o);
    end
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0; mask_i = 8'hFF;
    req_i = 8'b00000010; step();
    req_i = '0;          step();
    req_i = 8'b10000000; step();
    req_i = '0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_valid_o !== 1'b1 || out_num_o !== 3'd1 || pending_o !== 8'b10000010) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%b n=%0d p=%h exp v=1 n=1 p=82", k, out_valid_o, out_num_o, pending_o);
      end
      step();
    end
    out_ready_i = 1'b1;
    step();
    n_tests++;
    if (out_valid_o !== 1'b1 || out_num_o !== 3'd7 || pending_o !== 8'h80) begin
      n_fail++;
      $display("FAIL stall_next got v=%b n=%0d p=%h exp v=1 n=7 p=80", out_valid_o, out_num_o, pending_o);
    end
    step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      n_fail++;
      $display("FAIL stall_drain got v=%b p=%h exp v=0 p=00", out_valid_o, pending_o);
    end
  endtask

  task automatic test_mask();
    int exp_num[2] = '{5, 4};
    mask_i = 8'h0F; out_ready_i = 1'b1; req_i = 8'b00111000;
    step();
    req_i = '0;
    n_tests++;
    if (out_valid_o !== 1'b1 || out_num_o !== 3'd3) begin
      n_fail++;
      $display("FAIL mask_first got v=%b n=%0d exp v=1 n=3", out_valid_o, out_num_o);
    end
    step();
    step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'b00110000) begin
      n_fail++;
      $display("FAIL mask_retain got v=%b p=%h exp v=0 p=30", out_valid_o, pending_o);
    end
    mask_i = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if (out_valid_o !== 1'b1 || int'(out_num_o) != exp_num[k]) begin
        n_fail++;
        $display("FAIL mask_enable[%0d] got v=%b n=%0d exp v=1 n=%0d", k, out_valid_o, out_num_o, exp_num[k]);
      end
    end
    step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      n_fail++;
      $display("FAIL mask_drain got v=%b p=%h exp v=0 p=00", out_valid_o, pending_o);
    end
  endtask

  task automatic test_overflow();
    int ovf_seen;
    int dispatches;
    mask_i = 8'hFF; out_ready_i = 1'b0;
    req_i = 8'h01; step();
    n_tests++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_first got %b exp 0", overflow_o);
    end
    step();
    req_i = '0;
    n_tests++;
    if (overflow_o !== 1'b1 || pending_o !== 8'h01) begin
      n_fail++;
      $display("FAIL ovf_second got o=%b p=%h exp o=1 p=01", overflow_o, pending_o);
    end
    step();
    n_tests++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pulse got %b exp 0", overflow_o);
    end
    out_ready_i = 1'b1;
    dispatches = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid_o === 1'b1 && out_num_o === 3'd0) dispatches++;
      step();
    end
    n_tests++;
    if (dispatches != 1 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_once got dispatches=%0d v=%b exp 1 v=0", dispatches, out_valid_o);
    end
    // Re-request on the bit being served in the same cycle.
    req_i = 8'h01; step();
    step();
    req_i = '0;
    ovf_seen = overflow_o;
    n_tests++;
    if (ovf_seen != 0 || out_valid_o !== 1'b1 || out_num_o !== 3'd0 || pending_o !== 8'h01) begin
      n_fail++;
      $display("FAIL rereq got o=%0d v=%b n=%0d p=%h exp o=0 v=1 n=0 p=01", ovf_seen, out_valid_o, out_num_o, pending_o);
    end
    step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      n_fail++;
      $display("FAIL rereq_drain got v=%b p=%h exp v=0 p=00", out_valid_o, pending_o);
    end
  endtask

  task automatic test_reset_mid();
    mask_i = 8'hFF; out_ready_i = 1'b0; req_i = 8'hFF;
    step();
    step();
    req_i = '0;
    n_tests++;
    if (out_valid_o !== 1'b1 || out_num_o !== 3'd7 || pending_o !== 8'hFF || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got v=%b n=%0d p=%h o=%b exp v=1 n=7 p=ff o=1", out_valid_o, out_num_o, pending_o, overflow_o);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid_o, out_num_o, pending_o, overflow_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%b n=%0d p=%h o=%b exp all zero", out_valid_o, out_num_o, pending_o, overflow_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_after got v=%b p=%h exp v=0 p=00", out_valid_o, pending_o);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      req_i       = 8'($urandom & $urandom);
      mask_i      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      out_ready_i = ($urandom_range(0, 2) != 0);
      step();
      n_tests++;
      if (out_valid_o !== m_valid[0] || pending_o !== m_pend[7:0] || overflow_o !== m_ovf[0] ||
          (m_valid != 0 && out_num_o !== m_num[2:0])) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] got v=%b n=%0d p=%h o=%b exp v=%0d n=%0d p=%h o=%0d",
                   k, out_valid_o, out_num_o, pending_o, overflow_o, m_valid, m_num, m_pend[7:0], m_ovf);
      end
    end
    req_i = '0; out_ready_i = 1'b1; mask_i = 8'hFF;
    for (int k = 0; k < 10; k++) step();
    n_tests++;
    if (out_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      n_fail++;
      $display("FAIL random_drain got v=%b p=%h exp v=0 p=00", out_valid_o, pending_o);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_mask();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
